// File: rtl/led_bank_ctrl.sv
// LED bank controller: per-bank VALUE/MODE/DUTY registers on a shared
// tri-state bus, driving static, blink, PWM or off patterns onto LED.
module led_bank_ctrl #(
  parameter int         N_BANKS   = 2,
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int         BLINK_DIV = 25_000_000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [7:0]           BUS_DATA,
  input  logic [7:0]           BUS_ADDR,
  input  logic                 BUS_WE,
  output logic [8*N_BANKS-1:0] LED
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [8:0] WIN = 9'(4 * N_BANKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_PWM    = 2'd2,
    M_OFF    = 2'd3
  } mode_e;

  logic [7:0] value_q [N_BANKS];
  logic [7:0] value_d [N_BANKS];
  mode_e      mode_q  [N_BANKS];
  mode_e      mode_d  [N_BANKS];
  logic [7:0] duty_q  [N_BANKS];
  logic [7:0] duty_d  [N_BANKS];

  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   phase_q, phase_d;
  logic [7:0]             pwm_q, pwm_d;
  logic [8*N_BANKS-1:0]   led_q, led_d;

  logic [7:0] off;
  logic       in_win;
  logic [2:0] bsel;
  logic [1:0] ksel;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rd_data;

  // Offset wraps modulo 256; the >= test rejects addresses below the window.
  assign off    = BUS_ADDR - BASE_ADDR;
  assign in_win = (BUS_ADDR >= BASE_ADDR) && ({1'b0, off} < WIN);
  assign bsel   = off[4:2];
  assign ksel   = off[1:0];
  assign wr_en  = BUS_WE && in_win && (ksel != 2'd3);
  assign rd_en  = !BUS_WE && in_win;

  assign BUS_DATA = rd_en ? rd_data : 8'bzzzz_zzzz;
  assign LED      = led_q;

  always_comb begin
    rd_data = 8'h00;
    for (int b = 0; b < N_BANKS; b++) begin
      if (bsel == 3'(b)) begin
        unique case (ksel)
          2'd0:    rd_data = value_q[b];
          2'd1:    rd_data = {6'b0, mode_q[b]};
          2'd2:    rd_data = duty_q[b];
          default: rd_data = 8'h00;
        endcase
      end
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      value_d[b] = value_q[b];
      mode_d[b]  = mode_q[b];
      duty_d[b]  = duty_q[b];
      if (wr_en && (bsel == 3'(b))) begin
        unique case (ksel)
          2'd0:    value_d[b] = BUS_DATA;
          2'd1:    mode_d[b]  = mode_e'(BUS_DATA[1:0]);
          2'd2:    duty_d[b]  = BUS_DATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
    end
    pwm_d = pwm_q + 8'd1;
  end

  always_comb begin
    led_d = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      unique case (mode_q[b])
        M_STATIC: led_d[8*b +: 8] = value_q[b];
        M_BLINK:  led_d[8*b +: 8] = phase_q ? value_q[b] : 8'h00;
        M_PWM:    led_d[8*b +: 8] = (pwm_q < duty_q[b]) ? value_q[b] : 8'h00;
        M_OFF:    led_d[8*b +: 8] = 8'h00;
        default:  led_d[8*b +: 8] = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < N_BANKS; b++) begin
        value_q[b] <= 8'h00;
        mode_q[b]  <= M_STATIC;
        duty_q[b]  <= 8'h00;
      end
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pwm_q   <= 8'h00;
      led_q   <= '0;
    end else begin
      value_q <= value_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  end

endmodule
